cpu_datapath: RTL and testbench
===============================

CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 The block SHALL have these ports, one clock domain (clk; reset synchronous, active-low):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- pc_we, pc_sel, pc_jmp_sel  in  1 each  PC write, PC source (0 = PC+1, 1 = jump), jump base (0 = A, 1 = B)
- pc_offset, addr_offset  in  4 each  unsigned offsets
- addr_sel, mem_sel, mem_we  in  1 each  address source (0 = PC, 1 = reg+offset), address base (0 = A, 1 = B), memory write
- alu_opcode  in  3  ALU operation
- alu_sel_a, alu_sel_b, alu_we, zf_we  in  1 each  operand selects (0 = A, 1 = B), ALU register write, ZF write
- ir_we, a_sel, a_we, b_sel, b_we, halt  in  1 each  IR load, A/B source (0 = ALU reg, 1 = mem_rdata), A/B writes, halt request
- mem_rdata  in  8  memory read data, valid the cycle after mem_addr is presented
- mem_addr, mem_wdata  out  8 each  memory address and write data
- mem_we_o  out  1  gated memory write
- instr  out  8  IR contents, returned to the control unit
- zf, halted  out  1 each  zero flag and sticky halt flag
- pc, a_reg, b_reg  out  8 each  architectural registers

Function
REQ-002 All registers (PC, IR, A, B, ALU_R, ZF, HALTED) SHALL update only on the rising edge of clk.
REQ-003 When pc_we=1: with pc_sel=0, PC SHALL load PC+1 mod 256; with pc_sel=1, PC SHALL load (pc_jmp_sel ? B : A) + zero-extended pc_offset, mod 256.
REQ-004 mem_addr SHALL be combinational: PC when addr_sel=0, otherwise (mem_sel ? B : A) + zero-extended addr_offset, mod 256.
REQ-005 mem_wdata SHALL be the register not selected as base (mem_sel=0 gives B, mem_sel=1 gives A); mem_we_o SHALL equal mem_we AND NOT halted AND NOT halt.
REQ-006 When ir_we=1, IR SHALL load mem_rdata; instr SHALL equal IR.
REQ-007 ALU operands SHALL be opA = alu_sel_a ? B : A and opB = alu_sel_b ? B : A.
REQ-008 ALU opcodes SHALL be 000 = ADD (8-bit, carry discarded), 001 = AND, 010 = NOT opA.
REQ-009 When alu_we=1, ALU_R SHALL load the result. When zf_we=1, ZF SHALL load (result == 0); zf_we is independent of alu_we.
REQ-010 When a_we=1, A SHALL load (a_sel ? mem_rdata : ALU_R); B behaves the same way with b_we and b_sel. A and B may both be written in the same cycle, and both use pre-edge values.
REQ-011 When halt=1, HALTED SHALL set to 1 and remain set until reset.
REQ-012 While halt=1 or HALTED=1, every register write and mem_we_o SHALL be suppressed, including writes requested in the same cycle as halt.
REQ-013 Simultaneous writes SHALL read pre-edge values. Example: pc_we with base A in the same cycle as a_we uses the old A.

Reset
REQ-014 When reset=0 at a clock edge, PC, IR, A, B, ALU_R, ZF and HALTED SHALL all become 0, overriding every other input, including mid-instruction and while halted.
REQ-015 mem_we_o SHALL be 0 while reset=0.

Configuration
REQ-016 With CPU_ALU_EXT_EN defined, opcodes SHALL be 011 = SUB (opA-opB mod 256), 100 = OR, 101 = XOR, 110 = SHL opA by 1, 111 = SHR opA by 1 (logical).
REQ-017 Without CPU_ALU_EXT_EN, opcodes 011-111 SHALL give result 0, which sets ZF when zf_we=1.

Structure
REQ-018 The shared package cpu_pkg SHALL hold the ALU opcode constants, the select-encoding constants, and the control-unit FSM state constants (FETCH=000 ... IDLE=110).
REQ-019 The ALU SHALL be a combinational sub-module cpu_alu (opA, opB, opcode -> result); the datapath SHALL instantiate it once.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset: reset=0 for one edge with all write enables at 1 -> every output 0, mem_we_o=0.
- Fetch: PC=0x05, addr_sel=0, ir_we=1, mem_rdata=0x14 one cycle later -> mem_addr=0x05, instr=0x14. Then pc_we=1, pc_sel=0 -> pc=0x06. From PC=0xFF the same step gives pc=0x00.
- ALU: A=0x80, B=0x80, ADD with alu_we=1 and zf_we=1 -> ALU_R=0x00, zf=1. Then a_we=1, a_sel=0 -> a_reg=0x00. NOT with opA=0xFF -> 0x00, zf=1.
- Jump: B=0xF5, pc_we=1, pc_sel=1, pc_jmp_sel=1, pc_offset=0xF -> pc=0x04 (wrap).
- Memory: A=0x10, B=0x3C, addr_sel=1, mem_sel=0, addr_offset=3, mem_we=1 -> mem_addr=0x13, mem_wdata=0x3C, mem_we_o=1. Load with b_sel=1 and mem_rdata=0x7E -> b_reg=0x7E.
- Halt: halt=1 with pc_we=1 and a_we=1 -> pc and a_reg unchanged, halted=1, and still 1 ten cycles later. reset=0 -> halted=0. Opcode 011 with A=5, B=5 gives ALU_R=0 and zf=1 in both builds (5-5 with CPU_ALU_EXT_EN, forced 0 without). Opcode 100 with A=0x0F, B=0xF0 gives 0xFF with the macro and 0x00 without.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU datapath and its control unit.
// Holds ALU opcodes, select encodings and control-unit FSM state codes.
// Optional feature macro: CPU_ALU_EXT_EN (extended ALU opcodes 011-111).
package cpu_pkg;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_AND = 3'b001;
   localparam logic [2:0] OP_NOT = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_OR  = 3'b100;
   localparam logic [2:0] OP_XOR = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   // register select: A or B
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // PC source
   localparam logic PC_INC = 1'b0;
   localparam logic PC_JMP = 1'b1;

   // memory address source
   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_REG = 1'b1;

   // A/B load source
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   // control-unit sequencing states
   typedef enum logic [2:0] {
      FETCH      = 3'b000,
      DECODE     = 3'b001,
      EXECUTE    = 3'b010,
      MEM_ACCESS = 3'b011,
      WRITE_BACK = 3'b100,
      HALT_WAIT  = 3'b101,
      IDLE       = 3'b110
   } cpu_state_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 8-bit ALU.
// CPU_ALU_EXT_EN enables SUB/OR/XOR/SHL/SHR; otherwise those opcodes return 0.
module cpu_alu
   import cpu_pkg::*;
(
   input  logic [7:0] op_a,
   input  logic [7:0] op_b,
   input  logic [2:0] opcode,
   output logic [7:0] result
);

   // opcode decode; unused opcodes fall through to zero
   always_comb begin
      result = 8'h00;
      case (opcode)
         OP_ADD: result = op_a + op_b;
         OP_AND: result = op_a & op_b;
         OP_NOT: result = ~op_a;
`ifdef CPU_ALU_EXT_EN
         OP_SUB: result = op_a - op_b;
         OP_OR:  result = op_a | op_b;
         OP_XOR: result = op_a ^ op_b;
         OP_SHL: result = {op_a[6:0], 1'b0};
         OP_SHR: result = {1'b0, op_a[7:1]};
`endif
         default: result = 8'h00;
      endcase
   end

endmodule

// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: PC, IR, A, B, ALU result register, zero flag and
// sticky halt flag. A halt request blocks every write in its own cycle.
// Optional feature macro: CPU_ALU_EXT_EN (passed through to cpu_alu).
module cpu_datapath
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       pc_we,
   input  logic       pc_sel,
   input  logic       pc_jmp_sel,
   input  logic [3:0] pc_offset,
   input  logic [3:0] addr_offset,
   input  logic       addr_sel,
   input  logic       mem_sel,
   input  logic       mem_we,
   input  logic [2:0] alu_opcode,
   input  logic       alu_sel_a,
   input  logic       alu_sel_b,
   input  logic       alu_we,
   input  logic       zf_we,
   input  logic       ir_we,
   input  logic       a_sel,
   input  logic       a_we,
   input  logic       b_sel,
   input  logic       b_we,
   input  logic       halt,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_addr,
   output logic [7:0] mem_wdata,
   output logic       mem_we_o,
   output logic [7:0] instr,
   output logic       zf,
   output logic       halted,
   output logic [7:0] pc,
   output logic [7:0] a_reg,
   output logic [7:0] b_reg
);

   logic [7:0] pc_q, ir_q, a_q, b_q, alu_r;
   logic       zf_q, halted_q;
   logic [7:0] op_a, op_b, alu_res;
   logic [7:0] jmp_base, mem_base;
   logic       blocked;

   assign blocked  = halt | halted_q;

   assign op_a     = (alu_sel_a  == SEL_B) ? b_q : a_q;
   assign op_b     = (alu_sel_b  == SEL_B) ? b_q : a_q;
   assign jmp_base = (pc_jmp_sel == SEL_B) ? b_q : a_q;
   assign mem_base = (mem_sel    == SEL_B) ? b_q : a_q;

   assign mem_addr  = (addr_sel == ADDR_REG) ? (mem_base + {4'b0000, addr_offset}) : pc_q;
   assign mem_wdata = (mem_sel  == SEL_B) ? a_q : b_q;
   assign mem_we_o  = mem_we & ~blocked & reset;

   assign instr  = ir_q;
   assign zf     = zf_q;
   assign halted = halted_q;
   assign pc     = pc_q;
   assign a_reg  = a_q;
   assign b_reg  = b_q;

   cpu_alu u_alu (
      .op_a   (op_a),
      .op_b   (op_b),
      .opcode (alu_opcode),
      .result (alu_res)
   );

   // architectural register update; all sources are pre-edge values
   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_q     <= 8'h00;
         ir_q     <= 8'h00;
         a_q      <= 8'h00;
         b_q      <= 8'h00;
         alu_r    <= 8'h00;
         zf_q     <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         if (halt) halted_q <= 1'b1;
         if (!blocked) begin
            if (pc_we)  pc_q  <= (pc_sel == PC_JMP) ? (jmp_base + {4'b0000, pc_offset}) : (pc_q + 8'd1);
            if (ir_we)  ir_q  <= mem_rdata;
            if (a_we)   a_q   <= (a_sel == SRC_MEM) ? mem_rdata : alu_r;
            if (b_we)   b_q   <= (b_sel == SRC_MEM) ? mem_rdata : alu_r;
            if (alu_we) alu_r <= alu_res;
            if (zf_we)  zf_q  <= (alu_res == 8'h00);
         end
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath with a reference model and per-cycle compare.
// Honours CPU_ALU_EXT_EN the same way as the design build.
module tb_cpu_datapath;

   logic       clk = 1'b0;
   logic       reset;
   logic       pc_we, pc_sel, pc_jmp_sel;
   logic [3:0] pc_offset, addr_offset;
   logic       addr_sel, mem_sel, mem_we;
   logic [2:0] alu_opcode;
   logic       alu_sel_a, alu_sel_b, alu_we, zf_we;
   logic       ir_we, a_sel, a_we, b_sel, b_we, halt;
   logic [7:0] mem_rdata;
   logic [7:0] mem_addr, mem_wdata, instr, pc, a_reg, b_reg;
   logic       mem_we_o, zf, halted;

   int vectors    = 0;
   int miscompares = 0;
   bit chk_en     = 1'b0;

   // reference model state
   logic [7:0] m_pc, m_ir, m_a, m_b, m_alu;
   logic       m_zf, m_halted;

   cpu_datapath dut (
      .clk(clk), .reset(reset),
      .pc_we(pc_we), .pc_sel(pc_sel), .pc_jmp_sel(pc_jmp_sel),
      .pc_offset(pc_offset), .addr_offset(addr_offset),
      .addr_sel(addr_sel), .mem_sel(mem_sel), .mem_we(mem_we),
      .alu_opcode(alu_opcode), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
      .alu_we(alu_we), .zf_we(zf_we), .ir_we(ir_we),
      .a_sel(a_sel), .a_we(a_we), .b_sel(b_sel), .b_we(b_we), .halt(halt),
      .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we_o(mem_we_o), .instr(instr), .zf(zf), .halted(halted),
      .pc(pc), .a_reg(a_reg), .b_reg(b_reg)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(input logic [7:0] x, input logic [7:0] y, input logic [2:0] op);
      int r;
      r = 0;
      case (op)
         3'd0: r = (int'(x) + int'(y)) % 256;
         3'd1: r = int'(x & y);
         3'd2: r = 255 - int'(x);
`ifdef CPU_ALU_EXT_EN
         3'd3: r = (int'(x) - int'(y) + 256) % 256;
         3'd4: r = int'(x | y);
         3'd5: r = int'(x ^ y);
         3'd6: r = (int'(x) * 2) % 256;
         3'd7: r = int'(x) / 2;
`endif
         default: r = 0;
      endcase
      return 8'(r);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
      end
   endtask

   // model: next architectural state from the rules, using pre-edge values
   always @(posedge clk) begin
      logic [7:0] x, y, r;
      if (!reset) begin
         m_pc <= 0; m_ir <= 0; m_a <= 0; m_b <= 0; m_alu <= 0; m_zf <= 0; m_halted <= 0;
      end else if (halt || m_halted) begin
         m_halted <= 1'b1;
      end else begin
         x = alu_sel_a ? m_b : m_a;
         y = alu_sel_b ? m_b : m_a;
         r = alu_fn(x, y, alu_opcode);
         if (pc_we)  m_pc  <= pc_sel ? 8'((int'(pc_jmp_sel ? m_b : m_a) + int'(pc_offset)) % 256)
                                     : 8'((int'(m_pc) + 1) % 256);
         if (ir_we)  m_ir  <= mem_rdata;
         if (a_we)   m_a   <= a_sel ? mem_rdata : m_alu;
         if (b_we)   m_b   <= b_sel ? mem_rdata : m_alu;
         if (alu_we) m_alu <= r;
         if (zf_we)  m_zf  <= (r == 0);
      end
   end

   // per-cycle compare, mid low phase when inputs and outputs are settled
   always @(negedge clk) begin
      logic [7:0] e_addr;
      #3;
      if (chk_en) begin
         e_addr = addr_sel ? 8'((int'(mem_sel ? m_b : m_a) + int'(addr_offset)) % 256) : m_pc;
         chk("pc", pc, m_pc);
         chk("instr", instr, m_ir);
         chk("a_reg", a_reg, m_a);
         chk("b_reg", b_reg, m_b);
         chk("zf", {7'd0, zf}, {7'd0, m_zf});
         chk("halted", {7'd0, halted}, {7'd0, m_halted});
         chk("mem_addr", mem_addr, e_addr);
         chk("mem_wdata", mem_wdata, mem_sel ? m_a : m_b);
         chk("mem_we_o", {7'd0, mem_we_o}, {7'd0, mem_we && reset && !halt && !m_halted});
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #4;
   endtask

   task automatic idle_inputs();
      pc_we = 0; pc_sel = 0; pc_jmp_sel = 0; pc_offset = 0; addr_offset = 0;
      addr_sel = 0; mem_sel = 0; mem_we = 0; alu_opcode = 0;
      alu_sel_a = 0; alu_sel_b = 0; alu_we = 0; zf_we = 0;
      ir_we = 0; a_sel = 0; a_we = 0; b_sel = 0; b_we = 0; halt = 0;
      mem_rdata = 0;
   endtask

   task automatic load_ab(input logic [7:0] av, input logic [7:0] bv);
      idle_inputs();
      a_we = 1; a_sel = 1; mem_rdata = av; tick();
      idle_inputs();
      b_we = 1; b_sel = 1; mem_rdata = bv; tick();
      idle_inputs();
   endtask

   task automatic alu_op(input logic [2:0] op, input logic sa, input logic sb);
      idle_inputs();
      alu_opcode = op; alu_sel_a = sa; alu_sel_b = sb; alu_we = 1; zf_we = 1;
      tick();
      idle_inputs();
   endtask

   initial begin
      // reset with every write enable high
      idle_inputs();
      reset = 0;
      pc_we = 1; mem_we = 1; alu_we = 1; zf_we = 1; ir_we = 1; a_we = 1; b_we = 1;
      a_sel = 1; b_sel = 1; mem_rdata = 8'hAA;
      #1;
      chk("rst_mem_we_o", {7'd0, mem_we_o}, 8'h00);
      tick();
      chk_en = 1'b1;
      chk("rst_pc", pc, 8'h00);
      chk("rst_a", a_reg, 8'h00);
      chk("rst_b", b_reg, 8'h00);
      chk("rst_instr", instr, 8'h00);
      chk("rst_zf_halted", {6'd0, zf, halted}, 8'h00);
      reset = 1;
      idle_inputs();

      // fetch from PC=0x05
      load_ab(8'h05, 8'h00);
      pc_we = 1; pc_sel = 1; pc_jmp_sel = 0; pc_offset = 0; tick(); idle_inputs();
      chk("pc_set5", pc, 8'h05);
      #1;
      chk("fetch_addr", mem_addr, 8'h05);
      tick();
      ir_we = 1; mem_rdata = 8'h14; tick(); idle_inputs();
      chk("fetch_instr", instr, 8'h14);
      pc_we = 1; tick(); idle_inputs();
      chk("pc_inc", pc, 8'h06);
      load_ab(8'hFF, 8'h00);
      pc_we = 1; pc_sel = 1; tick(); idle_inputs();
      pc_we = 1; tick(); idle_inputs();
      chk("pc_wrap", pc, 8'h00);

      // ALU: ADD overflow to zero, then move to A
      load_ab(8'h80, 8'h80);
      alu_op(3'b000, 0, 1);
      chk("add_zf", {7'd0, zf}, 8'h01);
      a_we = 1; a_sel = 0; tick(); idle_inputs();
      chk("add_res", a_reg, 8'h00);
      load_ab(8'hFF, 8'h11);
      alu_op(3'b010, 0, 0);
      chk("not_zf", {7'd0, zf}, 8'h01);
      a_we = 1; tick(); idle_inputs();
      chk("not_res", a_reg, 8'h00);
      load_ab(8'h3C, 8'h0F);
      alu_op(3'b001, 0, 1);
      chk("and_zf", {7'd0, zf}, 8'h00);
      b_we = 1; b_sel = 0; tick(); idle_inputs();
      chk("and_res", b_reg, 8'h0C);

      // jump base B with offset wrap
      load_ab(8'h00, 8'hF5);
      pc_we = 1; pc_sel = 1; pc_jmp_sel = 1; pc_offset = 4'hF; tick(); idle_inputs();
      chk("jump_wrap", pc, 8'h04);

      // store address and data, then load into B
      load_ab(8'h10, 8'h3C);
      addr_sel = 1; mem_sel = 0; addr_offset = 4'd3; mem_we = 1;
      #1;
      chk("st_addr", mem_addr, 8'h13);
      chk("st_wdata", mem_wdata, 8'h3C);
      chk("st_we", {7'd0, mem_we_o}, 8'h01);
      tick(); idle_inputs();
      b_we = 1; b_sel = 1; mem_rdata = 8'h7E; tick(); idle_inputs();
      chk("ld_b", b_reg, 8'h7E);

      // simultaneous PC jump from A and A load sees old A
      load_ab(8'h20, 8'h00);
      pc_we = 1; pc_sel = 1; pc_offset = 4'd1; a_we = 1; a_sel = 1; mem_rdata = 8'h99;
      tick(); idle_inputs();
      chk("simul_pc", pc, 8'h21);
      chk("simul_a", a_reg, 8'h99);

      // opcode 011 on equal operands gives zero in both builds
      load_ab(8'h05, 8'h05);
      alu_op(3'b011, 0, 1);
      chk("op3_zf", {7'd0, zf}, 8'h01);
      a_we = 1; tick(); idle_inputs();
      chk("op3_res", a_reg, 8'h00);

      // opcode 100 differs by build
      load_ab(8'h0F, 8'hF0);
      alu_op(3'b100, 0, 1);
      a_we = 1; tick(); idle_inputs();
`ifdef CPU_ALU_EXT_EN
      chk("op4_res", a_reg, 8'hFF);
      chk("op4_zf", {7'd0, zf}, 8'h00);
`else
      chk("op4_res", a_reg, 8'h00);
      chk("op4_zf", {7'd0, zf}, 8'h01);
`endif

      // halt blocks same-cycle writes and sticks
      halt = 1; pc_we = 1; a_we = 1; a_sel = 1; mem_rdata = 8'h55; mem_we = 1;
      #1;
      chk("halt_we_o", {7'd0, mem_we_o}, 8'h00);
      tick(); idle_inputs();
      chk("halt_pc", pc, 8'h21);
`ifdef CPU_ALU_EXT_EN
      chk("halt_a", a_reg, 8'hFF);
`else
      chk("halt_a", a_reg, 8'h00);
`endif
      chk("halt_set", {7'd0, halted}, 8'h01);
      pc_we = 1; mem_we = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("halt_sticky", {7'd0, halted}, 8'h01);
      chk("halt_pc_hold", pc, 8'h21);
      reset = 0;
      tick();
      reset = 1; idle_inputs();
      chk("halt_cleared", {7'd0, halted}, 8'h00);
      chk("halt_rst_pc", pc, 8'h00);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
